// File: rtl/writeback_unit_pkg.sv
// writeback_unit_pkg: shared pipeline encodings for result-source and load-size selects.
package writeback_unit_pkg;
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_NPC = 2'd1;
    localparam logic [1:0] WB_MEM = 2'd2;
    localparam logic [1:0] WB_RSV = 2'd3;
    localparam logic [1:0] LD_B   = 2'd0;
    localparam logic [1:0] LD_H   = 2'd1;
    localparam logic [1:0] LD_W   = 2'd2;
endpackage

// File: rtl/writeback_unit_load_align.sv
// load_align: little-endian sub-word selection and sign/zero extension of a loaded memory word.
module load_align
    import writeback_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_mem,
    input  logic [1:0]      i_off,
    input  logic [1:0]      i_size,
    input  logic            i_uns,
    output logic [XLEN-1:0] o_data,
    output logic            o_mis
);
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_word;
    logic [XLEN-1:0] w_bext;
    logic [XLEN-1:0] w_hext;
    logic [XLEN-1:0] w_wext;

    assign w_byte = 8'(i_mem >> {i_off, 3'b000});
    assign w_half = 16'(i_mem >> {i_off[1], 4'b0000});
    assign w_word = 32'(i_mem);
    assign w_bext = i_uns ? XLEN'(w_byte) : XLEN'($signed(w_byte));
    assign w_hext = i_uns ? XLEN'(w_half) : XLEN'($signed(w_half));
    assign w_wext = i_uns ? XLEN'(w_word) : XLEN'($signed(w_word));
    // size 3 is treated as a word, so bit 1 alone identifies word loads
    assign o_data = i_size == LD_B ? w_bext : i_size == LD_H ? w_hext : w_wext;
    assign o_mis  = (i_size == LD_H && i_off[0]) || (i_size[1] && i_off != 2'd0);
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: MEM/WB register, result select, register-file write gating,
// forwarding shadow, retire counter and sticky error flag.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RADDR = 5,
    parameter int CNTW  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [XLEN-1:0]  alu_i,
    input  logic [XLEN-1:0]  npc_i,
    input  logic [XLEN-1:0]  mem_i,
    input  logic [1:0]       wbsel_i,
    input  logic             regwr_i,
    input  logic [RADDR-1:0] rd_i,
    input  logic [1:0]       ldsize_i,
    input  logic             ldunsigned_i,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic             rf_we_o,
    output logic [RADDR-1:0] rf_waddr_o,
    output logic [XLEN-1:0]  rf_wdata_o,
    output logic             prev_we_o,
    output logic [RADDR-1:0] prev_rd_o,
    output logic [XLEN-1:0]  prev_data_o,
    output logic [CNTW-1:0]  retired_o,
    output logic             err_o
);
    logic             r_valid;
    logic [XLEN-1:0]  r_alu;
    logic [XLEN-1:0]  r_npc;
    logic [XLEN-1:0]  r_mem;
    logic [1:0]       r_wbsel;
    logic             r_regwr;
    logic [RADDR-1:0] r_rd;
    logic [1:0]       r_ldsize;
    logic             r_lduns;
    logic             r_prev_we;
    logic [RADDR-1:0] r_prev_rd;
    logic [XLEN-1:0]  r_prev_data;
    logic [CNTW-1:0]  r_retired;
    logic             r_err;
    logic [XLEN-1:0]  w_ld;
    logic             w_ld_mis;
    logic             w_rsv;
    logic             w_mis;
    logic             w_retire;

    load_align #(.XLEN(XLEN)) u_align (
        .i_mem  (r_mem),
        .i_off  (r_alu[1:0]),
        .i_size (r_ldsize),
        .i_uns  (r_lduns),
        .o_data (w_ld),
        .o_mis  (w_ld_mis)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_alu    <= '0;
            r_npc    <= '0;
            r_mem    <= '0;
            r_wbsel  <= WB_ALU;
            r_regwr  <= 1'b0;
            r_rd     <= '0;
            r_ldsize <= LD_B;
            r_lduns  <= 1'b0;
        end else if (flush_i) begin
            r_valid  <= 1'b0;
        end else if (!stall_i) begin
            r_valid  <= valid_i;
            r_alu    <= alu_i;
            r_npc    <= npc_i;
            r_mem    <= mem_i;
            r_wbsel  <= wbsel_i;
            r_regwr  <= regwr_i;
            r_rd     <= rd_i;
            r_ldsize <= ldsize_i;
            r_lduns  <= ldunsigned_i;
        end
    end

    assign w_rsv    = r_wbsel == WB_RSV;
    assign w_mis    = r_wbsel == WB_MEM && w_ld_mis;
    assign w_retire = r_valid && !stall_i;

    assign rf_waddr_o = r_rd;
    assign rf_wdata_o = (w_rsv || w_mis) ? '0 :
                        r_wbsel == WB_ALU ? r_alu :
                        r_wbsel == WB_NPC ? r_npc : w_ld;
    // stall gates the enable so a held instruction writes only on release
    assign rf_we_o    = r_valid && r_regwr && |r_rd && !w_rsv && !w_mis && !stall_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_we   <= 1'b0;
            r_prev_rd   <= '0;
            r_prev_data <= '0;
            r_retired   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_prev_we   <= rf_we_o;
            r_prev_rd   <= rf_waddr_o;
            r_prev_data <= rf_wdata_o;
            if (w_retire)
                r_retired <= r_retired + CNTW'(1);
            if (w_retire && (w_rsv || w_mis))
                r_err <= 1'b1;
        end
    end

    assign prev_we_o   = r_prev_we;
    assign prev_rd_o   = r_prev_rd;
    assign prev_data_o = r_prev_data;
    assign retired_o   = r_retired;
    assign err_o       = r_err;
endmodule

// File: doc/writeback_unit.md
# writeback_unit

Parametrised write-back stage for the 5-stage pipeline. It holds the MEM/WB pipeline register with stall and flush. It selects the result source (ALU, next-PC, memory) and aligns and sign-extends sub-word loads. It drives the register-file write port, exports current and one-cycle-old write results to the forwarding unit, and keeps a retired-instruction counter and a sticky error flag.

## Interface
Parameters:
- XLEN, 32: datapath width; must be 32 or 64.
- RADDR, 5: register index width.
- CNTW, 32: retire counter width.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- valid_i  in  1  MEM stage holds a real instruction.
- alu_i  in  XLEN  ALU result; bits [1:0] also serve as the load byte offset.
- npc_i  in  XLEN  link value (PC+4).
- mem_i  in  XLEN  raw data-memory word.
- wbsel_i  in  2  source select: 0 = ALU, 1 = NPC, 2 = MEM, 3 = reserved.
- regwr_i  in  1  instruction writes rd.
- rd_i  in  RADDR  destination register.
- ldsize_i  in  2  0 = byte, 1 = half, 2 = word, 3 = word.
- ldunsigned_i  in  1  zero-extend instead of sign-extend.
- stall_i  in  1  hold the WB register.
- flush_i  in  1  insert a bubble.
- rf_we_o  out  1  register-file write enable.
- rf_waddr_o  out  RADDR  write address.
- rf_wdata_o  out  XLEN  write data.
- prev_we_o  out  1  write committed in the previous cycle.
- prev_rd_o  out  RADDR  rd of that write.
- prev_data_o  out  XLEN  data of that write.
- retired_o  out  CNTW  count of retired valid instructions.
- err_o  out  1  sticky: reserved wbsel or misaligned load seen.

## Operation
- WB register fields: valid, alu, npc, mem, wbsel, regwr, rd, ldsize, ldunsigned.
- Each rising edge:
  - If flush_i, valid ← 0; other fields don't-care. Flush has priority over stall.
  - Else if stall_i, hold all fields.
  - Else load all fields from the inputs.
- Load alignment (MEM source), little-endian, offset = alu[1:0]:
  - Byte: select mem byte[offset], then extend to XLEN.
  - Half: select the half at offset[1], then extend to XLEN.
  - Word: low 32 bits of mem, then extend to XLEN. With XLEN=32 the word passes unchanged.
  - Extension is sign-extension unless ldunsigned is set, in which case it is zero-extension.
- Misaligned load: MEM source with (half and offset[0]=1) or (word and offset≠0).
- Write data is combinational from the WB register: ALU → alu, NPC → npc, MEM → aligned data. Reserved select or a misaligned load gives 0.
- rf_we_o = valid & regwr & (rd≠0) & !reserved & !misaligned & !stall_i.
  - A stalled instruction writes only once, in the cycle stall is released.
- rf_waddr_o = rd, always driven.
- Retirement: a retire event is valid & !stall_i, whether or not the instruction writes. On each retire event retired_o increments and wraps modulo 2^CNTW.
- err_o sets when valid & !stall_i & (reserved | misaligned). Only rst clears it.
- Forward shadow: each edge, prev_we_o ← rf_we_o, prev_rd_o ← rf_waddr_o, prev_data_o ← rf_wdata_o. This covers register files without write-through.

## Timing
- Reset values: WB valid = 0; all WB fields = 0; rf_we_o = 0; rf_waddr_o = 0; rf_wdata_o = 0 (ALU select, alu = 0); prev_* = 0; retired_o = 0; err_o = 0.
- Latency: inputs presented at edge N appear on rf_* during cycle N+1. They appear on prev_* during cycle N+2.
- rf_* is combinational from registers only. There is no input-to-output combinational path except stall_i → rf_we_o.
- Flush and stall in the same cycle: a bubble is loaded.
- Reset asserted mid-stall: all state clears immediately; the held instruction is discarded and never written.
- rd = 0 with regwr: no write, but it still counts as retired.
- retired_o at all-ones plus one retire event gives 0, with no flag.

## Structure
- Shared pipeline package holds:
  - the wbsel encoding constants (WB_ALU = 0, WB_NPC = 1, WB_MEM = 2);
  - the ldsize encoding constants (LD_B, LD_H, LD_W).
- One sub-module: load_align (combinational). Inputs: mem word, offset, ldsize, ldunsigned. Outputs: aligned data, misaligned flag.
- The top level holds the WB register, source mux, write gating, counter, error flag and forward shadow.

## Test plan
- Reset, then ALU op: alu_i = 0x1234, regwr = 1, rd = 5. Required: next cycle rf_we = 1, waddr = 5, wdata = 0x1234. Following cycle prev_* carries the same write. retired_o = 1.
- Byte load: mem_i = 0x80FF7F01, offset 3, signed. Required: wdata = 0xFFFFFF80. Same with unsigned: wdata = 0x00000080. Half at offset 2, signed: wdata = 0xFFFF80FF.
- Misaligned half at offset 1. Required: rf_we = 0, err_o = 1 and stays set through later good instructions until rst.
- JAL-style: wbsel = 1, npc_i = 0x104, rd = 1, with stall held 3 cycles. Required: rf_we = 0 while stalled, a single write of 0x104 on release, retired increments by 1.
- Flush together with stall on a valid load. Required: bubble loaded; no write; retired unchanged. wbsel = 3 on a valid instruction: no write, err_o = 1.
- CNTW = 4: 17 retire events from reset. Required: retired_o = 1.
